// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and frame constants shared by the UART transmitter and receiver
package uart_pkg;
  localparam int DEFAULT_BAUD_SCALE = 10416;
  localparam int DATA_BITS = 8;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: clock-enable tick every BAUD_SCALE clk cycles, synchronously clearable
module uart_baud_tick import uart_pkg::*; #(
  parameter int BAUD_SCALE = DEFAULT_BAUD_SCALE
) (
  input  logic clk,
  input  logic nreset,
  input  logic clear,
  output logic tick
);
  localparam int W = (BAUD_SCALE > 1) ? $clog2(BAUD_SCALE) : 1;
  logic [W-1:0] r_cnt;
  assign tick = (r_cnt == W'(BAUD_SCALE - 1));
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_cnt <= '0;
    else r_cnt <= (clear || tick) ? '0 : r_cnt + W'(1);
  end
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter with start/ready handshake and done pulse
module uart_transmitter import uart_pkg::*; #(
  parameter int BAUD_SCALE = DEFAULT_BAUD_SCALE,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       ready,
  output logic       done
);
  logic [1:0]           r_state;
  logic [2:0]           r_bit;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 w_tick;
  logic                 w_accept;
  logic [2:0]           w_idx;
  // Holding the counter clear in IDLE makes every START begin with a fresh count
  uart_baud_tick #(.BAUD_SCALE(BAUD_SCALE)) u_tick (
    .clk    (clk),
    .nreset (nreset),
    .clear  (r_state == ST_IDLE),
    .tick   (w_tick)
  );
  assign ready    = (r_state == ST_IDLE);
  assign w_accept = start && ready;
  assign done     = (r_state == ST_STOP) && w_tick;
  assign w_idx    = MSB_FIRST ? 3'd7 - r_bit : r_bit;
  assign txd      = (r_state == ST_DATA) ? r_shreg[w_idx] : (r_state != ST_START);
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
      r_bit   <= '0;
      r_shreg <= '0;
    end else if (w_accept) begin
      r_state <= ST_START;
      r_bit   <= '0;
      r_shreg <= data;
    end else if (w_tick) begin
      if (r_state == ST_START) r_state <= ST_DATA;
      else if (r_state == ST_DATA) begin
        r_bit <= r_bit + 3'd1;
        if (r_bit == 3'd7) r_state <= ST_STOP;
      end else if (r_state == ST_STOP) r_state <= ST_IDLE;
    end
  end
endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter BAUD_SCALE, default 10416, meaning clk cycles per serial bit (9600 baud at 100 MHz; benches use 2 or 4).
REQ-002 SHALL have parameter MSB_FIRST, default 0, meaning data bit order (0 = LSB first, 1 = MSB first).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port nreset, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, transmit request.
REQ-006 SHALL have port data, input, 8, byte to transmit; sampled only when a request is accepted.
REQ-007 SHALL have port txd, output, 1, serial line; idle high.
REQ-008 SHALL have port ready, output, 1, high only when a start request will be accepted.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when the stop bit completes.

Function
REQ-010 SHALL implement states IDLE, START, DATA, STOP.
REQ-011 SHALL drive txd as follows: IDLE = 1, START = 0, DATA = current data bit, STOP = 1.
REQ-012 SHALL drive ready = 1 only in IDLE.
REQ-013 SHALL accept a request when start = 1 and ready = 1 at a clk edge.
REQ-014 On acceptance, SHALL latch data into a shift register, enter START, and drive txd = 0 from the next cycle (latency 1 cycle).
REQ-015 SHALL ignore start when ready = 0; data changes after acceptance SHALL NOT affect the frame.
REQ-016 SHALL hold each bit (start, 8 data, stop) on txd for exactly BAUD_SCALE clk cycles, so one frame lasts 10*BAUD_SCALE cycles.
REQ-017 SHALL time each bit with a tick counter clocked by clk (clock enable only, no derived or divided clock).
- Counter resets to 0 on every state entry.
- Counter wraps at BAUD_SCALE-1.
REQ-018 SHALL index data bits with a 3-bit counter: START to DATA at tick; DATA to STOP after the tick of bit index 7; STOP to IDLE at tick.
REQ-019 SHALL assert done for exactly the one cycle in which STOP exits to IDLE; ready SHALL rise in the following cycle.
REQ-020 SHALL accept a start asserted in the first IDLE cycle after done; this gives back-to-back frames with no idle bit between them.
REQ-021 SHALL send bit order per MSB_FIRST; the default is LSB first (8N1).
REQ-022 SHALL support BAUD_SCALE >= 2; BAUD_SCALE = 1 is unsupported.

Reset
REQ-023 While nreset = 0, SHALL immediately force all of the following, independent of clk, including mid-frame:
- state = IDLE, txd = 1, ready = 1, done = 0;
- tick and bit counters = 0;
- shift register = 0.
REQ-024 A frame interrupted by reset SHALL be abandoned, not resumed.
REQ-025 The first request SHALL be accepted on the first clk edge after nreset deasserts.

Structure
REQ-026 SHALL place the following in shared package uart_pkg, for reuse by the receiver:
- state encoding constants;
- DEFAULT_BAUD_SCALE = 10416;
- DATA_BITS = 8.
REQ-027 SHALL place the tick counter in one sub-module, uart_baud_tick, with:
- inputs clk, nreset, clear (synchronous);
- output tick;
- parameter BAUD_SCALE.

Verification
REQ-028 SHALL check (BAUD_SCALE=4): start pulse with data=0xA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; done pulses once at cycle 40 after acceptance.
REQ-029 SHALL check (MSB_FIRST=1, BAUD_SCALE=2): data=0x81 -> txd 0,1,0,0,0,0,0,0,1,1, each bit held 2 cycles.
REQ-030 SHALL check: start held high while data changes 0x3C->0xFF mid-frame -> 0x3C sent; second request accepted in the first IDLE cycle; 0xFF follows with no idle gap.
REQ-031 SHALL check: nreset pulsed low during bit 3 of the frame -> txd = 1 and ready = 1 within the same cycle; no done pulse; next frame 0x55 correct.
REQ-032 SHALL check: start asserted while ready = 0 -> no effect; exactly one frame for the accepted byte; ready low for exactly 10*BAUD_SCALE cycles.
REQ-033 SHALL loop back txd into the existing receiver (BAUD_SCALE=2) -> its result equals the sent byte for 0x00, 0xFF, 0x5A.
